// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader FSM state encoding and the default NOP instruction word.
// Imported by imem_loader.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_LO = 2'd1,
    ST_LOAD_HI = 2'd2,
    ST_RUN     = 2'd3
  } imem_state_t;

  localparam logic [15:0] IMEM_NOP_DEFAULT = 16'h0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: 2^ADDR_W x DATA_W simple dual-port, block-RAM inferable.
// Latency: write takes effect on the edge; read data is registered (1 cycle).
// Backpressure: none; both ports accept every cycle their enable is high.
// Ports: i_clk; write port i_we/i_waddr/i_wdata; read port i_re/i_raddr -> o_rdata.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // No reset on the array or the read register so synthesis can map both
  // into a block RAM and its output register.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder: byte-stream program loader plus 1-cycle CPU fetch port.
// Latency: instr_out follows pc_in by one cycle in RUN; NOP_INSTR otherwise.
// Backpressure: ld_ready high only while loading; bytes offered outside a load are ignored.
// Ports: clk, rst_n (async low); pc_in -> instr_out, cpu_run; load stream
//        ld_start, ld_valid/ld_ready, ld_data, ld_last; sticky ld_overflow.
// Build option: define IMEM_CHECKSUM_EN to add ld_checksum (mod-2^16 sum of words written this load).
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] NOP_INSTR = IMEM_NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  output logic [15:0] instr_out,
  output logic        cpu_run,
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
`ifdef IMEM_CHECKSUM_EN
  output logic [15:0] ld_checksum,
`endif
  output logic        ld_overflow
);

  imem_state_t       r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [7:0]        r_byte_lo;
  logic              r_ld_ready;
  logic              r_cpu_run;
  logic              r_ld_overflow;
  logic              r_fetch_ok;

  logic              w_xfer;
  logic              w_we;
  logic [15:0]       w_wdata;
  logic [15:0]       w_ram_q;
  logic              w_pc_ok;

  // ld_start wins over a coincident byte: that byte is dropped.
  assign w_xfer  = ld_valid & r_ld_ready & ~ld_start;
  assign w_pc_ok = ((pc_in >> ADDR_W) == 16'd0);

  // A RAM write happens on a high byte, or on a low byte that ends the load
  // (odd-length program: the high half of the last word is zero).
  always_comb begin
    w_we    = 1'b0;
    w_wdata = {ld_data, r_byte_lo};
    if (w_xfer) begin
      case (r_state)
        ST_LOAD_LO: begin
          if (ld_last) begin
            w_we    = 1'b1;
            w_wdata = {8'h00, ld_data};
          end
        end
        ST_LOAD_HI: w_we = 1'b1;
        default:    w_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_byte_lo     <= 8'h00;
      r_ld_ready    <= 1'b0;
      r_cpu_run     <= 1'b0;
      r_ld_overflow <= 1'b0;
      r_fetch_ok    <= 1'b0;
    end else begin
      // Selects the RAM read register onto instr_out for the next cycle.
      r_fetch_ok <= (r_state == ST_RUN) && w_pc_ok;

      if (ld_start) begin
        r_state       <= ST_LOAD_LO;
        r_wr_ptr      <= '0;
        r_ld_overflow <= 1'b0;
        r_ld_ready    <= 1'b1;
        r_cpu_run     <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD_LO: begin
            if (w_xfer) begin
              r_byte_lo <= ld_data;
              if (ld_last) begin
                r_state    <= ST_RUN;
                r_ld_ready <= 1'b0;
                r_cpu_run  <= 1'b1;
              end else begin
                r_state <= ST_LOAD_HI;
              end
            end
          end
          ST_LOAD_HI: begin
            if (w_xfer) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (ld_last || (r_wr_ptr == '1)) begin
                // Filling the last word without ld_last means the stream is
                // longer than the RAM: flag it and start running what we have.
                r_ld_overflow <= ~ld_last;
                r_state       <= ST_RUN;
                r_ld_ready    <= 1'b0;
                r_cpu_run     <= 1'b1;
              end else begin
                r_state <= ST_LOAD_LO;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 16'h0000;
    end else if (ld_start) begin
      r_checksum <= 16'h0000;
    end else if (w_we) begin
      r_checksum <= r_checksum + w_wdata;
    end
  end

  assign ld_checksum = r_checksum;
`endif

  // Load writes and fetch reads are confined to disjoint states, so the two
  // RAM ports never touch the same word in the same cycle.
  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (r_state == ST_RUN),
    .i_raddr (pc_in[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  // The RAM read register is the instruction register; the select is itself
  // a flop, so instr_out drops to NOP asynchronously on reset.
  assign instr_out   = r_fetch_ok ? w_ram_q : NOP_INSTR;
  assign cpu_run     = r_cpu_run;
  assign ld_ready    = r_ld_ready;
  assign ld_overflow = r_ld_overflow;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Instruction-memory responder on the CPU's fetch interface: receives the CPU's next-PC and returns the 16-bit instruction word.
Holds a 2^ADDR_W x 16 instruction RAM, filled at runtime over a byte-wide valid/ready load stream, so programs change without resynthesis.
A small FSM arbitrates between loading and running, and holds the CPU in NOP while a load is in progress.

Parameters:
ADDR_W, 8, instruction RAM address width; depth = 2^ADDR_W words
NOP_INSTR, 16'h0000, word driven on instr_out when not running or when the PC is out of range

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_in  input  16  next PC from CPU (word address)
instr_out  output  16  instruction for CPU, registered
cpu_run  output  1  high only in RUN; CPU may treat low as stall
ld_start  input  1  single-cycle pulse; begins a new load at word 0
ld_valid  input  1  ld_data holds a byte
ld_ready  output  1  loader accepts a byte this cycle
ld_data  input  8  load byte, low byte of each word first
ld_last  input  1  qualifies final byte, sampled with ld_valid
ld_overflow  output  1  sticky: load exceeded depth; cleared by ld_start or reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, instr_out=NOP_INSTR, cpu_run=0, ld_ready=0, ld_overflow=0, wr_ptr=0, byte_lo=0. RAM contents not reset.
- Byte transfer happens on a clock edge with ld_valid & ld_ready.
- FSM states:
  - IDLE: waits for ld_start; goes to LOAD_LO.
  - LOAD_LO: ld_ready=1. On transfer, latch byte_lo.
    - ld_last=0: go to LOAD_HI.
    - ld_last=1: write {8'h00, byte} at wr_ptr, go to RUN.
  - LOAD_HI: ld_ready=1. On transfer, write {ld_data, byte_lo} at wr_ptr and increment wr_ptr.
    - ld_last=1: go to RUN.
    - wr_ptr was 2^ADDR_W-1 and ld_last=0: set ld_overflow, go to RUN. wr_ptr wraps to 0; no further writes.
    - otherwise: go to LOAD_LO.
  - RUN: cpu_run=1, ld_ready=0.
- ld_start in any state (including mid-load, and during RUN) restarts the load: wr_ptr=0, ld_overflow=0, go to LOAD_LO. Words already written stay in RAM.
- ld_start has priority over a simultaneous byte transfer; that byte is dropped.
- Fetch in RUN: instr_out <= mem[pc_in[ADDR_W-1:0]] every cycle, one-cycle latency.
  - If pc_in[15:ADDR_W] != 0, instr_out <= NOP_INSTR.
- Outside RUN: instr_out <= NOP_INSTR.
- On the RUN-entry edge, instr_out is still NOP_INSTR. The first real fetch is visible one cycle after entry.
- RAM has a single write port (load) and a single read port (fetch). They never operate in the same state, so there are no read/write collisions.
- ld_valid while ld_ready=0 is ignored. No data is buffered.

Optional Feature:
IMEM_CHECKSUM_EN.
- Defined: adds output ld_checksum[15:0].
  - Mod-2^16 sum of every word written during the current load.
  - Cleared to 0 by reset and by ld_start.
  - Updated on the same edge as the RAM write.
  - Holds its value in RUN.
- Undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package imem_pkg: FSM state encoding (IDLE, LOAD_LO, LOAD_HI, RUN) and the default NOP_INSTR constant.
- One sub-module, imem_ram: 2^ADDR_W x 16 simple dual-port RAM with a synchronous write port and a synchronous registered read port, inferable as block RAM.
- FSM, pointer and out-of-range muxing stay in imem_loader.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, release, no ld_start, pc_in=0 -> cpu_run=0, instr_out=16'h0000, ld_ready=0 for 10 cycles.
2. Basic load and fetch:
   - Stimulus: ld_start, then bytes 34,12,78,56 with ld_last on 56.
   - Load response: mem[0]=16'h1234, mem[1]=16'h5678, cpu_run rises the next edge.
   - Fetch: pc_in=1 -> instr_out=16'h5678 one cycle later; pc_in=16'h0100 (ADDR_W=8) -> 16'h0000.
3. Odd-length load: bytes AA,BB,CC with ld_last on CC -> mem[1]=16'h00CC, state RUN, ld_overflow=0.
4. Backpressure and gaps: ld_valid toggled randomly over 6 bytes -> RAM contents match; in RUN, ld_valid=1 is ignored and ld_ready=0.
5. Overflow: ADDR_W=2, 10 bytes without ld_last -> mem[0..3] written, ld_overflow=1 after byte 8, RUN entered, bytes 9-10 not accepted.
6. Restart and reset mid-load:
   - ld_start coincident with a byte transfer mid-load -> byte dropped, wr_ptr=0, state LOAD_LO.
   - rst_n asserted mid-load -> outputs at reset values immediately, without waiting for a clock edge.
   - With IMEM_CHECKSUM_EN: after load 1234,5678 -> ld_checksum=16'h68AC.
